// File: rtl/fan_red_pipe_pkg.sv
// Shared types and constants for the forwarding-adder-network reduction pipe.
// Lane count, data width and the derived index width / latency live here so
// every file agrees on them.
package fan_pkg;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int LGN = $clog2(N);
  localparam int LAT = LGN + 2;

  typedef logic [W-1:0]   data_t;
  typedef logic [LGN-1:0] idx_t;
  typedef data_t [N-1:0]  vec_t;
  typedef idx_t  [N-1:0]  idxv_t;

  // One pipeline slot. open[i]=1 means lane i's partial sum has not yet
  // reached the head of its segment, so it may still absorb lanes to its left.
  typedef struct packed {
    vec_t           data;
    logic [N-1:0]   open;
    logic [N-1:0]   split;
    idxv_t          idx;
    logic           acc;
  } stage_t;

  // A lane starts a segment when it is lane 0 or its left neighbour ends one.
  function automatic logic [N-1:0] open_init(input logic [N-1:0] split);
    logic [N-1:0] o;
    o[0] = 1'b0;
    for (int i = 1; i < N; i++) begin
      o[i] = ~split[i-1];
    end
    return o;
  endfunction

endpackage

// File: rtl/fan_red_pipe_scan_level.sv
// One registered level of the segmented inclusive scan, distance D.
// A lane still open (no segment head in its covered window) adds the partial
// sum D lanes to its left and inherits that lane's open flag; the covered
// window doubles each level.
module fan_scan_level
  import fan_pkg::*;
#(
  parameter int D = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   en_i,
  input  logic   valid_i,
  input  stage_t stage_i,
  output logic   valid_o,
  output stage_t stage_o
);

  stage_t stage_d;
  stage_t stage_q;
  logic   valid_q;

  // Combine each open lane with the lane D to its left.
  always_comb begin
    stage_d = stage_i;
    for (int i = D; i < N; i++) begin
      if (stage_i.open[i]) begin
        stage_d.data[i] = stage_i.data[i] + stage_i.data[i-D];
        stage_d.open[i] = stage_i.open[i-D];
      end
    end
  end

  // Level register; holds while the pipe is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      stage_q <= stage_d;
    end
  end

  assign valid_o = valid_q;
  assign stage_o = stage_q;

endmodule

// File: rtl/fan_red_pipe.sv
// fan_red_pipe: pipelined segmented reduction (forwarding adder network).
// Input register, LGN scan levels, scatter/output register.
// Optional feature macro: FAN_ACC_EN (output-stationary accumulate into the
// held output using in_acc). Without it in_acc is ignored.
//
// Handshake: an input vector transfers on a rising edge where
// in_valid && in_ready; an output vector transfers where out_valid && out_ready.
// out_valid && !out_ready is a stall that freezes every stage, so
// in_ready = !out_valid || out_ready; nothing is dropped or duplicated.
module fan_red_pipe
  import fan_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  vec_t         in_data,
  input  logic [N-1:0] in_split,
  input  idxv_t        in_out_idx,
  input  logic         in_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output vec_t         out_data,
  output logic [31:0]  delay,
  output logic [31:0]  num_el
);

  logic         en;
  logic         out_valid_q;
  vec_t         out_data_q;
  vec_t         out_data_d;

  stage_t       s0_d;
  stage_t       s0_q;
  logic         s0_valid_q;
  logic [N-1:0] split_eff;

  stage_t       lvl_stage [LGN];
  logic         lvl_valid [LGN];
  stage_t       last;
  logic         last_valid;

  vec_t         slot_val;
  logic [N-1:0] slot_hit;

  assign en       = ~(out_valid_q & ~out_ready);
  assign in_ready = en;

  // Build the stage-0 payload; lane N-1 always closes the last segment.
  always_comb begin
    s0_d         = '0;
    split_eff    = in_split;
    split_eff[N-1] = 1'b1;
    s0_d.data    = in_data;
    s0_d.split   = split_eff;
    s0_d.open    = open_init(split_eff);
    s0_d.idx     = in_out_idx;
`ifdef FAN_ACC_EN
    s0_d.acc     = in_acc;
`else
    s0_d.acc     = 1'b0;
`endif
  end

`ifndef FAN_ACC_EN
  logic unused_acc;
  assign unused_acc = in_acc;
`endif

  // Input register; bubbles enter as valid=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_q       <= '0;
    end else if (en) begin
      s0_valid_q <= in_valid;
      s0_q       <= s0_d;
    end
  end

  generate
    for (genvar k = 0; k < LGN; k++) begin : g_lvl
      stage_t st_in;
      logic   v_in;
      if (k == 0) begin : g_first
        assign st_in = s0_q;
        assign v_in  = s0_valid_q;
      end else begin : g_rest
        assign st_in = lvl_stage[k-1];
        assign v_in  = lvl_valid[k-1];
      end
      fan_scan_level #(.D(1 << k)) u_level (
        .clock   (clock),
        .reset   (reset),
        .en_i    (en),
        .valid_i (v_in),
        .stage_i (st_in),
        .valid_o (lvl_valid[k]),
        .stage_o (lvl_stage[k])
      );
    end
  endgenerate

  assign last       = lvl_stage[LGN-1];
  assign last_valid = lvl_valid[LGN-1];

  logic [N:0] unused_bits;
  assign unused_bits = {last.open, last.acc};

  // Scatter segment ends to their slots; ascending lane order lets the
  // highest lane win on duplicate indices.
  always_comb begin
    slot_val = '0;
    slot_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (last.split[i]) begin
        slot_val[last.idx[i]] = last.data[i];
        slot_hit[last.idx[i]] = 1'b1;
      end
    end
  end

  // Next output vector: overwrite, or accumulate into the held output.
  always_comb begin
    out_data_d = '0;
    for (int j = 0; j < N; j++) begin
`ifdef FAN_ACC_EN
      if (last.acc) begin
        out_data_d[j] = slot_hit[j] ? out_data_q[j] + slot_val[j] : out_data_q[j];
      end else begin
        out_data_d[j] = slot_hit[j] ? slot_val[j] : '0;
      end
`else
      out_data_d[j] = slot_hit[j] ? slot_val[j] : '0;
`endif
    end
  end

  // Output register; data only changes when a real vector arrives so the
  // held result survives bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign delay     = 32'(LAT);
  assign num_el    = 32'(N);

endmodule

// File: tb/tb_fan_red_pipe.sv
// Directed bench for fan_red_pipe: driver tasks push hand-computed expected
// vectors into a queue at accept time; a monitor pops on every output transfer.
module tb_fan_red_pipe;
  import fan_pkg::*;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  vec_t         in_data;
  logic [N-1:0] in_split;
  idxv_t        in_out_idx;
  logic         in_acc;
  logic         out_valid;
  logic         out_ready;
  vec_t         out_data;
  logic [31:0]  delay;
  logic [31:0]  num_el;

  logic [N*W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  fan_red_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_split   (in_split),
    .in_out_idx (in_out_idx),
    .in_acc     (in_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .delay      (delay),
    .num_el     (num_el)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N*W-1:0] got,
                       input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got=%h exp=none", out_data);
      end else begin
        logic [N*W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL out_data got=%h exp=%h", out_data, e);
        end
      end
    end
  end

  // driver: one attempt, returns whether the vector was accepted
  task automatic try_send(input vec_t d, input logic [N-1:0] s, input idxv_t x,
                          input logic a, input bit push, input vec_t e,
                          output bit ok);
    @(negedge clock);
    in_data    = d;
    in_split   = s;
    in_out_idx = x;
    in_acc     = a;
    in_valid   = 1'b1;
    #1;
    ok = in_ready;
    @(posedge clock);
    if (ok && push) exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input vec_t d, input logic [N-1:0] s, input idxv_t x,
                      input logic a, input bit push, input vec_t e);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      try_send(d, s, x, a, push, e, ok);
      n++;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clock);
      t++;
    end
    repeat (2) @(posedge clock);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  vec_t         d, e;
  logic [N-1:0] s;
  idxv_t        x;
  int           lat;
  int           acc_cnt;
  bit           ok;

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_split   = '0;
    in_out_idx = '0;
    in_acc     = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("delay_const", delay, 6);
    check("num_el_const", num_el, 16);

    // T1: one segment, data i+1 -> slot 3 = 136, latency
    for (int i = 0; i < N; i++) d[i] = data_t'(i + 1);
    s = '0; x = '0; x[15] = idx_t'(3);
    e = '0; e[3] = 8'd136;
    send(d, s, x, 1'b0, 1'b1, e);
    lat = 0;
    @(negedge clock); #1;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock); #1;
    end
    check("t1_latency_incl_accept", lat + 1, 6);
    drain();

    // T2: every lane its own segment, reversed indices
    for (int i = 0; i < N; i++) begin
      d[i] = data_t'(i);
      x[i] = idx_t'(15 - i);
      e[i] = data_t'(15 - i);
    end
    s = '1;
    send(d, s, x, 1'b0, 1'b1, e);

    // T3: wrap, all 8'hFF -> 16*255 mod 256 = 8'hF0
    for (int i = 0; i < N; i++) d[i] = 8'hFF;
    s = '0; x = '0; x[15] = idx_t'(9);
    e = '0; e[9] = 8'hF0;
    send(d, s, x, 1'b0, 1'b1, e);

    // T4a: segments [0..3],[4..15], data 1 -> out0=4, out1=12
    for (int i = 0; i < N; i++) d[i] = 8'd1;
    s = '0; s[3] = 1'b1; x = '0; x[3] = idx_t'(0); x[15] = idx_t'(1);
    e = '0; e[0] = 8'd4; e[1] = 8'd12;
    send(d, s, x, 1'b0, 1'b1, e);

    // T4b: duplicate idx 5, lane 15 wins -> out5=12
    x = '0; x[3] = idx_t'(5); x[15] = idx_t'(5);
    e = '0; e[5] = 8'd12;
    send(d, s, x, 1'b0, 1'b1, e);

    // T4c: segments [0..2],[3..9],[10..15], data i+1 -> 6, 49, 81
    for (int i = 0; i < N; i++) d[i] = data_t'(i + 1);
    s = '0; s[2] = 1'b1; s[9] = 1'b1;
    x = '0; x[2] = idx_t'(1); x[9] = idx_t'(2); x[15] = idx_t'(3);
    e = '0; e[1] = 8'd6; e[2] = 8'd49; e[3] = 8'd81;
    send(d, s, x, 1'b0, 1'b1, e);
    drain();

    // T5: backpressure, 8 vectors with out_ready low
    @(negedge clock);
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc_cnt < 8) begin
        for (int l = 0; l < N; l++) d[l] = data_t'(acc_cnt + 1);
        s = '0; x = '0; x[15] = idx_t'(acc_cnt);
        e = '0; e[acc_cnt] = data_t'(16 * (acc_cnt + 1));
        try_send(d, s, x, 1'b0, 1'b1, e, ok);
        if (ok) acc_cnt++;
      end
    end
    check("t5_accepts_before_stall", acc_cnt, 6);
    @(negedge clock); #1;
    check("t5_in_ready_low", in_ready, 0);
    check("t5_out_valid_held", out_valid, 1);
    @(negedge clock);
    out_ready = 1'b1;
    while (acc_cnt < 8) begin
      for (int l = 0; l < N; l++) d[l] = data_t'(acc_cnt + 1);
      s = '0; x = '0; x[15] = idx_t'(acc_cnt);
      e = '0; e[acc_cnt] = data_t'(16 * (acc_cnt + 1));
      send(d, s, x, 1'b0, 1'b1, e);
      acc_cnt++;
    end
    drain();

    // T6: reset with two vectors in flight; neither may appear
    for (int i = 0; i < N; i++) d[i] = 8'd7;
    s = '0; x = '0; e = '0;
    send(d, s, x, 1'b0, 1'b0, e);
    send(d, s, x, 1'b0, 1'b0, e);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_out_valid_after_reset", out_valid, 0);
    check("t6_out_data_after_reset", out_data, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_in_ready_after_reset", in_ready, 1);
    repeat (LAT + 4) @(posedge clock);

    // post-reset sanity vector
    for (int i = 0; i < N; i++) d[i] = data_t'(i + 1);
    s = '0; x = '0; x[15] = idx_t'(11);
    e = '0; e[11] = 8'd136;
    send(d, s, x, 1'b0, 1'b1, e);
    drain();

    // T7: A acc=0 then B acc=1
    d = '0; d[0] = 8'd1; d[1] = 8'd2; d[2] = 8'd3; d[3] = 8'd4; d[4] = 8'd9;
    s = '0; s[3] = 1'b1; x = '0; x[3] = idx_t'(2); x[15] = idx_t'(6);
    e = '0; e[2] = 8'd10; e[6] = 8'd9;
    send(d, s, x, 1'b0, 1'b1, e);
    d = '0; d[0] = 8'd5; d[5] = 8'd3;
    s = '0; s[4] = 1'b1; x = '0; x[4] = idx_t'(2); x[15] = idx_t'(7);
`ifdef FAN_ACC_EN
    e = '0; e[2] = 8'd15; e[6] = 8'd9; e[7] = 8'd3;
`else
    e = '0; e[2] = 8'd5; e[7] = 8'd3;
`endif
    send(d, s, x, 1'b1, 1'b1, e);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
